// File: rtl/thistle_alu.sv
// Registered WIDTH-bit ALU: add/sub with carry, logic ops, 1-bit shifts, pass-through.
// Optional registered Z/N/V flags when THISTLE_ALU_FLAGS_EN is defined.
module thistle_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryIn,
   input  logic             en_b,
   input  logic [2:0]       op,
`ifdef THISTLE_ALU_FLAGS_EN
   output logic [2:0]       flags,
`endif
   output logic [WIDTH-1:0] out,
   output logic             carryOut
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_SHL  = 3'd5,
      OP_SHR  = 3'd6,
      OP_PASS = 3'd7
   } alu_op_e;

   alu_op_e          op_e;
   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] out_d, out_q;
   logic             carry_d, carry_q;

   assign op_e = alu_op_e'(op);
   assign bx   = en_b ? b : '0;

   // SUB reuses the adder: a + ~bx + carryIn, so carryIn=1 means "no borrow".
   assign addend = (op_e == OP_SUB) ? ~bx : bx;
   assign sum    = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, carryIn};

   always_comb begin
      out_d   = '0;
      carry_d = 1'b0;
      case (op_e)
         OP_ADD,
         OP_SUB:  {carry_d, out_d} = sum;
         OP_AND:  out_d = a & bx;
         OP_OR:   out_d = a | bx;
         OP_XOR:  out_d = a ^ bx;
         OP_SHL: begin
            out_d   = {a[WIDTH-2:0], carryIn};
            carry_d = a[WIDTH-1];
         end
         OP_SHR: begin
            out_d   = {carryIn, a[WIDTH-1:1]};
            carry_d = a[0];
         end
         OP_PASS: begin
            out_d   = bx;
            carry_d = carryIn;
         end
         default: begin
            out_d   = '0;
            carry_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         carry_q <= carry_d;
      end
   end

   assign out      = out_q;
   assign carryOut = carry_q;

`ifdef THISTLE_ALU_FLAGS_EN
   logic [2:0] flags_d, flags_q;
   logic       ovf;

   // Overflow: both adder inputs share a sign and the result sign differs.
   assign ovf = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      flags_d    = '0;
      flags_d[0] = (out_d == '0);
      flags_d[1] = out_d[WIDTH-1];
      flags_d[2] = ((op_e == OP_ADD) || (op_e == OP_SUB)) ? ovf : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= '0;
      else        flags_q <= flags_d;
   end

   assign flags = flags_q;
`endif

endmodule

// File: tb/tb_thistle_alu.sv
// Directed self-checking bench for thistle_alu; checks {carryOut,out} (and flags if built).
module tb_thistle_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] a, b;
   logic         carryIn, en_b;
   logic [2:0]   op;
   logic [W-1:0] out;
   logic         carryOut;
`ifdef THISTLE_ALU_FLAGS_EN
   logic [2:0]   flags;
`endif

   int n_vec = 0;
   int n_err = 0;

   thistle_alu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .carryIn  (carryIn),
      .en_b     (en_b),
      .op       (op),
`ifdef THISTLE_ALU_FLAGS_EN
      .flags    (flags),
`endif
      .out      (out),
      .carryOut (carryOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W:0] exp);
      n_vec++;
      assert ({carryOut, out} === exp) else begin
         n_err++;
         $error("FAIL %s: got co=%b out=%h, expected co=%b out=%h",
                tag, carryOut, out, exp[W], exp[W-1:0]);
      end
   endtask

`ifdef THISTLE_ALU_FLAGS_EN
   task automatic chk_flags(input string tag, input logic [2:0] exp);
      n_vec++;
      assert (flags === exp) else begin
         n_err++;
         $error("FAIL %s: got flags=%b, expected flags=%b", tag, flags, exp);
      end
   endtask
`endif

   // Drive inputs (called just after a rising edge), then sample 1 time unit after the next edge.
   task automatic step(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ci, input logic eb);
      op = o; a = ia; b = ib; carryIn = ci; en_b = eb;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset applied while clk is low, with live inputs on the bus
      rst_n = 1'b1;
      op = 3'd0; a = 8'h55; b = 8'h0F; carryIn = 1'b1; en_b = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_immediate", 9'h000);
`ifdef THISTLE_ALU_FLAGS_EN
      chk_flags("reset_flags", 3'b000);
`endif
      @(posedge clk); #1;
      chk("reset_held", 9'h000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_release_add", 9'h065);

      // ADD with en_b gating
      step(3'd0, 8'h10, 8'h20, 1'b1, 1'b0); chk("add_enb0",      9'h011);
      step(3'd0, 8'h00, 8'h20, 1'b1, 1'b0); chk("add_a0_enb0",   9'h001);
      step(3'd0, 8'h00, 8'h20, 1'b1, 1'b1); chk("add_enb1",      9'h021);
      step(3'd0, 8'h01, 8'h20, 1'b1, 1'b1); chk("add_a1",        9'h022);
      step(3'd0, 8'h01, 8'h02, 1'b1, 1'b1); chk("add_b2",        9'h004);

      // Inputs changing between edges must not disturb the registered result
      a = 8'hAA; b = 8'h33; #3;
      chk("hold_between_edges", 9'h004);

      // ADD wrap-around and overflow
      step(3'd0, 8'hFF, 8'h01, 1'b0, 1'b1); chk("add_wrap", 9'h100);
`ifdef THISTLE_ALU_FLAGS_EN
      chk_flags("add_wrap_flags", 3'b001);
`endif
      step(3'd0, 8'hFF, 8'h00, 1'b1, 1'b1); chk("add_wrap_cin", 9'h100);
      step(3'd0, 8'h7F, 8'h01, 1'b0, 1'b1); chk("add_ovf", 9'h080);
`ifdef THISTLE_ALU_FLAGS_EN
      chk_flags("add_ovf_flags", 3'b110);
`endif

      // SUB
      step(3'd1, 8'h05, 8'h03, 1'b1, 1'b1); chk("sub_5_3",       9'h102);
      step(3'd1, 8'h00, 8'h01, 1'b1, 1'b1); chk("sub_borrow",    9'h0FF);
`ifdef THISTLE_ALU_FLAGS_EN
      chk_flags("sub_borrow_flags", 3'b010);
`endif
      step(3'd1, 8'h10, 8'h55, 1'b0, 1'b0); chk("sub_enb0_cin0", 9'h10F);
      step(3'd1, 8'h10, 8'h55, 1'b1, 1'b0); chk("sub_enb0_cin1", 9'h110);
      step(3'd1, 8'h80, 8'h01, 1'b1, 1'b1); chk("sub_ovf",       9'h17F);
`ifdef THISTLE_ALU_FLAGS_EN
      chk_flags("sub_ovf_flags", 3'b100);
`endif

      // Logic ops (carryIn set to show carryOut is forced low)
      step(3'd2, 8'hF0, 8'h3C, 1'b1, 1'b1); chk("and",      9'h030);
      step(3'd3, 8'hF0, 8'h3C, 1'b1, 1'b1); chk("or",       9'h0FC);
      step(3'd4, 8'hF0, 8'h3C, 1'b1, 1'b1); chk("xor",      9'h0CC);
`ifdef THISTLE_ALU_FLAGS_EN
      chk_flags("xor_flags", 3'b010);
`endif
      step(3'd2, 8'hF0, 8'h3C, 1'b1, 1'b0); chk("and_enb0", 9'h000);
      step(3'd3, 8'hF0, 8'h3C, 1'b0, 1'b0); chk("or_enb0",  9'h0F0);

      // Shifts and pass
      step(3'd5, 8'h81, 8'h00, 1'b0, 1'b1); chk("shl",       9'h102);
      step(3'd5, 8'h40, 8'h00, 1'b1, 1'b1); chk("shl_cin",   9'h081);
      step(3'd6, 8'h81, 8'h00, 1'b1, 1'b1); chk("shr",       9'h1C0);
      step(3'd6, 8'h02, 8'h00, 1'b0, 1'b1); chk("shr_cin0",  9'h001);
      step(3'd7, 8'h00, 8'h3C, 1'b1, 1'b1); chk("pass",      9'h13C);
      step(3'd7, 8'h00, 8'h3C, 1'b0, 1'b0); chk("pass_enb0", 9'h000);

      // Mid-stream reset: pulse low between edges during ADD traffic
      step(3'd0, 8'h30, 8'h12, 1'b0, 1'b1); chk("pre_reset_add", 9'h042);
      a = 8'h01; b = 8'h01;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_reset_clear", 9'h000);
      #1;
      rst_n = 1'b1;
      #1;
      chk("mid_reset_released_no_edge", 9'h000);
      @(posedge clk); #1;
      chk("mid_reset_resume", 9'h002);
      step(3'd0, 8'hFE, 8'h01, 1'b1, 1'b1); chk("post_reset_add", 9'h100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #100000;
      n_err++;
      $display("FAIL watchdog: timeout reached, expected bench completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
